// File: rtl/countdown_timer.sv
// Loadable down-counting timer.
// A start/reload value is taken over a valid/ready handshake. Once started,
// the count drops by one per clock. At terminal count a one-cycle `expired`
// pulse is produced, and the timer either reloads (auto-reload mode) or
// returns to IDLE (one-shot mode). `pause` holds the count and `abort`
// cancels the timer without producing an expiry.
module countdown_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expired
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        RUN    = 2'd2,
        PAUSED = 2'd3
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [WIDTH-1:0]  count_reg;
    logic [WIDTH-1:0]  count_next;
    logic [WIDTH-1:0]  reload_reg;
    logic [WIDTH-1:0]  reload_next;
    logic              mode_reg;
    logic              mode_next;
    logic              expired_reg;
    logic              expired_next;

    // A count of 0 or 1 is treated as terminal, so the decrement can never
    // wrap and a load value of 0 expires on the first RUN edge.
    logic              at_terminal;
    assign at_terminal = (count_reg <= WIDTH'(1));

    // State and datapath registers; reset returns to an empty, idle timer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            reload_reg  <= '0;
            mode_reg    <= 1'b0;
            expired_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            reload_reg  <= reload_next;
            mode_reg    <= mode_next;
            expired_reg <= expired_next;
        end
    end

    // Next-state and datapath update; abort beats pause, pause beats expiry.
    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        reload_next  = reload_reg;
        mode_next    = mode_reg;
        expired_next = 1'b0;

        if (abort) begin
            // Cancel without expiry; reload value and mode are kept.
            state_next = IDLE;
            count_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load_valid) begin
                        count_next  = load_value;
                        reload_next = load_value;
                        mode_next   = auto_reload;
                        state_next  = LOADED;
                    end
                end
                LOADED: begin
                    // The start edge only arms the timer; counting begins on
                    // the following edge.
                    if (start) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_next = PAUSED;
                    end else if (!at_terminal) begin
                        count_next = count_reg - WIDTH'(1);
                    end else begin
                        expired_next = 1'b1;
                        if (mode_reg) begin
                            count_next = reload_reg;
                        end else begin
                            count_next = '0;
                            state_next = IDLE;
                        end
                    end
                end
                PAUSED: begin
                    // The resume edge does not decrement, so every paused
                    // cycle plus the resume edge stretches the period.
                    if (!pause) begin
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from registered state only.
    assign load_ready = (state_reg == IDLE);
    assign busy       = (state_reg == RUN) || (state_reg == PAUSED);
    assign count      = count_reg;
    assign expired    = expired_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed testbench for countdown_timer: a 32-bit instance for the main
// behaviour and a 4-bit instance for the no-wrap corner case.
module tb_countdown_timer;

    logic        clock;
    logic        reset_n;

    // 32-bit instance
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_value;
    logic        auto_reload;
    logic        start;
    logic        pause;
    logic        abort;
    logic [31:0] count;
    logic        busy;
    logic        expired;

    // 4-bit instance
    logic        n_load_valid;
    logic        n_load_ready;
    logic [3:0]  n_load_value;
    logic        n_auto_reload;
    logic        n_start;
    logic        n_pause;
    logic        n_abort;
    logic [3:0]  n_count;
    logic        n_busy;
    logic        n_expired;

    int errors;
    int checks;

    countdown_timer #(.WIDTH(32)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_value  (load_value),
        .auto_reload (auto_reload),
        .start       (start),
        .pause       (pause),
        .abort       (abort),
        .count       (count),
        .busy        (busy),
        .expired     (expired)
    );

    countdown_timer #(.WIDTH(4)) dut4 (
        .clock       (clock),
        .reset_n     (reset_n),
        .load_valid  (n_load_valid),
        .load_ready  (n_load_ready),
        .load_value  (n_load_value),
        .auto_reload (n_auto_reload),
        .start       (n_start),
        .pause       (n_pause),
        .abort       (n_abort),
        .count       (n_count),
        .busy        (n_busy),
        .expired     (n_expired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [31:0] val, input logic mode);
        $display("load value=%0d auto_reload=%0d", val, mode);
        load_valid  = 1'b1;
        load_value  = val;
        auto_reload = mode;
        tick();
        load_valid  = 1'b0;
        check("loaded_ready", load_ready, 0);
        check("loaded_count", count, val);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        reset_n       = 1'b0;
        load_valid    = 1'b0;
        load_value    = '0;
        auto_reload   = 1'b0;
        start         = 1'b0;
        pause         = 1'b0;
        abort         = 1'b0;
        n_load_valid  = 1'b0;
        n_load_value  = '0;
        n_auto_reload = 1'b0;
        n_start       = 1'b0;
        n_pause       = 1'b0;
        n_abort       = 1'b0;

        // Reset values
        #3;
        check("rst_count", count, 0);
        check("rst_ready", load_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_expired", expired, 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("idle_ready", load_ready, 1);

        // Start without a load is ignored
        $display("start with no load");
        do_start();
        check("nostart_busy", busy, 0);
        check("nostart_ready", load_ready, 1);
        check("nostart_count", count, 0);

        // One-shot load 5
        do_load(32'd5, 1'b0);
        // load_valid while LOADED is ignored
        load_valid = 1'b1;
        load_value = 32'd9;
        pause      = 1'b1;
        tick();
        load_valid = 1'b0;
        pause      = 1'b0;
        check("loaded_ignore_count", count, 5);
        check("loaded_ignore_busy", busy, 0);
        do_start();
        check("os_start_count", count, 5);
        check("os_start_busy", busy, 1);
        for (int k = 4; k >= 1; k--) begin
            tick();
            check("os_count", count, k);
            check("os_noexp", expired, 0);
        end
        tick();
        check("os_expired", expired, 1);
        check("os_end_count", count, 0);
        check("os_end_busy", busy, 0);
        check("os_end_ready", load_ready, 1);
        tick();
        check("os_pulse_one_cycle", expired, 0);

        // Auto-reload load 3: period 3, sequence 3,2,1,3,...
        do_load(32'd3, 1'b1);
        do_start();
        check("ar_start_count", count, 3);
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("ar_count", count, (k % 3 == 0) ? 32'd3 : 32'(3 - (k % 3)));
            check("ar_expired", expired, (k % 3 == 0) ? 32'd1 : 32'd0);
            check("ar_busy", busy, 1);
        end
        do_abort();
        check("ar_abort_ready", load_ready, 1);
        check("ar_abort_count", count, 0);

        // Pause for two edges at count 2 (load 4)
        do_load(32'd4, 1'b0);
        do_start();
        tick();
        check("p_count3", count, 3);
        tick();
        check("p_count2", count, 2);
        pause = 1'b1;
        tick();
        check("p_hold_a", count, 2);
        check("p_busy", busy, 1);
        tick();
        check("p_hold_b", count, 2);
        pause = 1'b0;
        tick();
        check("p_resume_count", count, 2);
        check("p_resume_noexp", expired, 0);
        tick();
        check("p_count1", count, 1);
        tick();
        check("p_expired", expired, 1);
        check("p_end_count", count, 0);

        // Pause on the expiry edge
        do_load(32'd2, 1'b0);
        do_start();
        tick();
        check("pe_count1", count, 1);
        pause = 1'b1;
        tick();
        check("pe_hold_noexp", expired, 0);
        check("pe_hold_count", count, 1);
        tick();
        check("pe_hold2_noexp", expired, 0);
        pause = 1'b0;
        tick();
        check("pe_resume_noexp", expired, 0);
        check("pe_resume_count", count, 1);
        tick();
        check("pe_expired", expired, 1);
        check("pe_ready", load_ready, 1);

        // Abort during RUN at count 7 (load 10)
        do_load(32'd10, 1'b0);
        do_start();
        tick();
        tick();
        tick();
        check("ab_count7", count, 7);
        do_abort();
        check("ab_ready", load_ready, 1);
        check("ab_count", count, 0);
        check("ab_noexp", expired, 0);
        check("ab_busy", busy, 0);
        tick();
        check("ab_noexp_late", expired, 0);

        // Abort together with start in LOADED
        do_load(32'd6, 1'b0);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abs_ready", load_ready, 1);
        check("abs_busy", busy, 0);
        check("abs_count", count, 0);

        // Load 0 one-shot
        do_load(32'd0, 1'b0);
        do_start();
        check("z_busy", busy, 1);
        check("z_noexp", expired, 0);
        tick();
        check("z_expired", expired, 1);
        check("z_ready", load_ready, 1);

        // Load 0 auto-reload expires every RUN edge
        do_load(32'd0, 1'b1);
        do_start();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("zar_expired", expired, 1);
            check("zar_count", count, 0);
        end
        do_abort();
        check("zar_abort_ready", load_ready, 1);

        // load_valid during RUN is ignored
        do_load(32'd5, 1'b0);
        do_start();
        load_valid = 1'b1;
        load_value = 32'd99;
        check("lr_run_ready", load_ready, 0);
        tick();
        check("lr_run_count4", count, 4);
        tick();
        check("lr_run_count3", count, 3);
        load_valid = 1'b0;
        do_abort();

        // Asynchronous reset in the middle of a run
        do_load(32'd3, 1'b0);
        do_start();
        tick();
        $display("reset mid-run");
        reset_n = 1'b0;
        #1;
        check("mr_async_count", count, 0);
        check("mr_async_ready", load_ready, 1);
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mr_noexp", expired, 0);
            check("mr_idle", load_ready, 1);
        end

        // WIDTH=4, load 15: counts down with no wrap
        $display("load value=15 auto_reload=0 (4-bit)");
        n_load_valid = 1'b1;
        n_load_value = 4'd15;
        tick();
        n_load_valid = 1'b0;
        n_start = 1'b1;
        tick();
        n_start = 1'b0;
        check("w4_start", 32'(n_count), 15);
        for (int k = 1; k <= 14; k++) begin
            tick();
            check("w4_count", 32'(n_count), 32'(15 - k));
            check("w4_noexp", n_expired, 0);
        end
        tick();
        check("w4_expired", n_expired, 1);
        check("w4_end_count", 32'(n_count), 0);
        check("w4_ready", n_load_ready, 1);
        tick();
        check("w4_no_wrap", 32'(n_count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counting timer: the count-down counterpart to the free-running synchronous up counter in the counter module family. A value is loaded over a valid/ready handshake, counted down one per clock while running, and a one-cycle `expired` pulse flags terminal count. Sits beside the up counter as the shared timeout/period generator for control blocks; supports one-shot and auto-reload modes, pause and abort.

## Interface
- `WIDTH`, 32, width of load value, count and reload registers

- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `load_valid`  in  1  load request; value on `load_value` offered
- `load_ready`  out  1  block accepts a load; high only in IDLE
- `load_value`  in  WIDTH  start/reload value, captured on handshake
- `auto_reload`  in  1  mode bit, captured with `load_value` on handshake
- `start`  in  1  begin counting from the loaded value (honoured in LOADED only)
- `pause`  in  1  level: hold count while high
- `abort`  in  1  return to IDLE immediately, no expiry
- `count`  out  WIDTH  current count value (registered)
- `busy`  out  1  high in RUN or PAUSED
- `expired`  out  1  registered one-cycle pulse at terminal count

## Operation
- States: IDLE, LOADED, RUN, PAUSED. Reset → IDLE.
- Handshake: a load is accepted when `load_valid && load_ready` at a rising edge. `load_ready` = (state == IDLE), combinational from state. On acceptance: `count` ← `load_value`, `reload` ← `load_value`, `mode` ← `auto_reload`, state → LOADED.
- LOADED: `start` → RUN with no decrement that edge. `load_valid` is ignored. `pause` has no effect.
- RUN, at each edge:
  - `pause` high → PAUSED; count holds.
  - Otherwise, if `count > 1`: `count` ← `count − 1`.
  - Otherwise (`count` is 0 or 1): `expired` ← 1. If `mode` is set, `count` ← `reload` and stay in RUN. If not, `count` ← 0 and go to IDLE.
- PAUSED: `count` holds. At the first edge with `pause` low → RUN, with no decrement that edge.
- `abort` at an edge, from any state → IDLE, `count` ← 0, `expired` ← 0. `reload` and `mode` are unchanged.
- Priority: `abort` > `pause` > expiry/decrement. `start` in IDLE, RUN or PAUSED is ignored.
- Arithmetic: unsigned, WIDTH bits. The decrement never wraps below 0.
- Load value 0: expires at the first RUN edge. With auto-reload it expires at every RUN edge.
- `expired` defaults to 0 each cycle unless set by the rule above.

## Timing
- Reset values (asynchronous, while `reset_n` = 0): state IDLE, `count` 0, `reload` 0, `mode` 0, `expired` 0, `busy` 0, `load_ready` 1.
- Reset deasserted mid-run: the block restarts in IDLE; no `expired` is produced.
- With load value N ≥ 1 and `start` sampled at edge E0:
  - `count` shows N after E0 and N−k after edge Ek.
  - `expired` is high for the cycle following edge EN.
  - One-shot: `count` shows 0 and `load_ready` is 1 in that same cycle.
- Auto-reload period is exactly N cycles. `count` shows N again in the cycle where `expired` is high.
- Each cycle spent with `pause` high in RUN/PAUSED adds exactly one cycle, plus one cycle for the resume edge.
- `busy` is registered-state decoded; it is high from the cycle after the `start` edge until the cycle after expiry (one-shot) or abort.

## Test plan
- Reset/idle: `reset_n` low, then released → `count`=0, `load_ready`=1, `busy`=0, `expired`=0; `start` with no load → no change.
- One-shot: load 5, `start` → `count` 5,4,3,2,1 on successive cycles, then `expired`=1 for one cycle with `count`=0, `busy`=0, `load_ready`=1.
- Auto-reload: load 3 with `auto_reload`=1, `start`, run 10 cycles → `expired` pulses every 3 cycles; `count` sequence 3,2,1,3,2,1…
- Pause: load 4, `start`, hold `pause` high for 2 edges when `count`=2 → `count` holds at 2; `expired` is delayed by 3 cycles versus an unpaused run. Assert `pause` on the expiry edge (`count`=1) → no pulse until resumed.
- Abort: abort during RUN at `count`=7 (load 10) → next cycle IDLE, `count`=0, no `expired`. Abort together with `start` in LOADED → IDLE.
- Corner cases:
  - Load 0 one-shot → `expired` one cycle after `start`.
  - `load_valid` during RUN → `load_ready`=0, value ignored.
  - WIDTH=4 with load 15 → counts 15 down to expiry with no wrap.
